// File: rtl/spi_flash_reader_pkg.sv
// Shared constants, state encodings and header helper for the SPI flash reader.
// SPI_FLASH_READER_FAST_READ_EN selects FAST_READ (0x0B + dummy byte) over READ (0x03).
package spi_flash_pkg;

    localparam logic [2:0] REG_RXDATA  = 3'd0;
    localparam logic [2:0] REG_TXDATA  = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_CONTROL = 3'd3;
    localparam logic [2:0] REG_SSEL    = 3'd5;

    localparam logic [7:0]  OPCODE_READ      = 8'h03;
    localparam logic [7:0]  OPCODE_FAST_READ = 8'h0B;
    localparam logic [15:0] CONTROL_SSO      = 16'h0400;

`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam logic [7:0] HDR_OPCODE = OPCODE_FAST_READ;
    localparam logic [2:0] HDR_LEN    = 3'd5;
`else
    localparam logic [7:0] HDR_OPCODE = OPCODE_READ;
    localparam logic [2:0] HDR_LEN    = 3'd4;
`endif

    typedef enum logic [3:0] {
        IDLE,
        SSO_ON,
        WAIT_TRDY,
        TX_WR,
        WAIT_RRDY,
        RX_RD,
        EMIT,
        SSO_OFF,
        FIN
    } state_t;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_CYC1,
        ACC_CYC2,
        ACC_GAP
    } acc_state_t;

    // Header byte by position; positions past the address are the fast-read dummy byte.
    function automatic logic [7:0] header_byte(input logic [2:0] idx, input logic [23:0] a);
        case (idx)
            3'd0:    header_byte = HDR_OPCODE;
            3'd1:    header_byte = a[23:16];
            3'd2:    header_byte = a[15:8];
            3'd3:    header_byte = a[7:0];
            default: header_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// Register-port bus between the flash reader (master) and the SPI master core (slave).
interface spi_flash_reader_if;

    logic        spi_select;
    logic        spi_read_n;
    logic        spi_write_n;
    logic [2:0]  spi_addr;
    logic [15:0] spi_wdata;
    logic [15:0] spi_rdata;
    logic        spi_readyfordata;
    logic        spi_dataavailable;

    modport master (
        output spi_select, spi_read_n, spi_write_n, spi_addr, spi_wdata,
        input  spi_rdata, spi_readyfordata, spi_dataavailable
    );

    modport slave (
        input  spi_select, spi_read_n, spi_write_n, spi_addr, spi_wdata,
        output spi_rdata, spi_readyfordata, spi_dataavailable
    );

endinterface

// File: rtl/spi_flash_bus_access.sv
// Two-cycle register access sequencer followed by one idle gap cycle carrying ack.
module spi_flash_bus_access
    import spi_flash_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    spi_flash_reader_if.master spi
);

    acc_state_t acc_q, acc_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc_q <= ACC_IDLE;
        else          acc_q <= acc_d;
    end

    // A request is only taken from ACC_IDLE, so a held req during the ack/gap cycle never re-issues.
    always_comb begin
        acc_d = acc_q;
        case (acc_q)
            ACC_IDLE: if (req) acc_d = ACC_CYC1;
            ACC_CYC1: acc_d = ACC_CYC2;
            ACC_CYC2: acc_d = ACC_GAP;
            ACC_GAP:  acc_d = ACC_IDLE;
            default:  acc_d = ACC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi.spi_select  <= 1'b0;
            spi.spi_read_n  <= 1'b1;
            spi.spi_write_n <= 1'b1;
            spi.spi_addr    <= '0;
            spi.spi_wdata   <= '0;
            ack             <= 1'b0;
            rdata           <= '0;
        end else begin
            ack <= 1'b0;
            case (acc_q)
                ACC_IDLE: begin
                    if (req) begin
                        spi.spi_select  <= 1'b1;
                        spi.spi_read_n  <= we;
                        spi.spi_write_n <= !we;
                        spi.spi_addr    <= addr;
                        spi.spi_wdata   <= wdata;
                    end
                end
                ACC_CYC2: begin
                    spi.spi_select  <= 1'b0;
                    spi.spi_read_n  <= 1'b1;
                    spi.spi_write_n <= 1'b1;
                    ack             <= 1'b1;
                    if (!spi.spi_read_n) rdata <= spi.spi_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// Streams bytes from an SPI flash through a register-mapped SPI master core.
// Define SPI_FLASH_READER_FAST_READ_EN for the FAST_READ command with one dummy byte.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int unsigned MAX_LEN = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    spi_flash_reader_if.master spi
);

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    state_t      state_q, state_d;
    logic [23:0] addr_q;
    logic [15:0] remaining_q;
    logic [2:0]  hdr_cnt_q;
    logic [15:0] len_eff;
    logic        hdr_done;
    logic [7:0]  tx_byte;

    logic        bus_req;
    logic        bus_we;
    logic [2:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic [15:0] bus_rdata;
    logic [7:0]  unused_rdata_hi;

    assign unused_rdata_hi = bus_rdata[15:8];
    assign len_eff  = (len > MAX_LEN_W) ? MAX_LEN_W : len;
    assign hdr_done = (hdr_cnt_q == HDR_LEN);
    // Header bytes first, then one 0x00 per requested data byte.
    assign tx_byte  = hdr_done ? 8'h00 : header_byte(hdr_cnt_q, addr_q);

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIN);

    spi_flash_bus_access u_bus (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus_req),
        .we      (bus_we),
        .addr    (bus_addr),
        .wdata   (bus_wdata),
        .ack     (bus_ack),
        .rdata   (bus_rdata),
        .spi     (spi)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        bus_req   = 1'b0;
        bus_we    = 1'b1;
        bus_addr  = REG_CONTROL;
        bus_wdata = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (len_eff == '0) ? FIN : SSO_ON;
            end
            SSO_ON: begin
                bus_req   = 1'b1;
                bus_wdata = CONTROL_SSO;
                if (bus_ack) state_d = WAIT_TRDY;
            end
            WAIT_TRDY: begin
                if (spi.spi_readyfordata) state_d = TX_WR;
            end
            TX_WR: begin
                bus_req   = 1'b1;
                bus_addr  = REG_TXDATA;
                bus_wdata = {8'h00, tx_byte};
                if (bus_ack) state_d = WAIT_RRDY;
            end
            WAIT_RRDY: begin
                if (spi.spi_dataavailable) state_d = RX_RD;
            end
            RX_RD: begin
                bus_req  = 1'b1;
                bus_we   = 1'b0;
                bus_addr = REG_RXDATA;
                if (bus_ack) state_d = hdr_done ? EMIT : WAIT_TRDY;
            end
            EMIT: begin
                if (rd_ready) state_d = (remaining_q <= 16'd1) ? SSO_OFF : WAIT_TRDY;
            end
            SSO_OFF: begin
                bus_req = 1'b1;
                if (bus_ack) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            hdr_cnt_q   <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q      <= addr;
                        remaining_q <= len_eff;
                        hdr_cnt_q   <= '0;
                    end
                end
                RX_RD: begin
                    if (bus_ack) begin
                        if (!hdr_done) begin
                            hdr_cnt_q <= hdr_cnt_q + 3'd1;
                        end else begin
                            rd_data  <= bus_rdata[7:0];
                            rd_valid <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (remaining_q != '0) remaining_q <= remaining_q - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural SPI master register port.
module tb_spi_flash_reader;
    import spi_flash_pkg::*;

`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam int unsigned TB_HDR = 5;
    localparam logic [7:0]  TB_OPC = 8'h0B;
`else
    localparam int unsigned TB_HDR = 4;
    localparam logic [7:0]  TB_OPC = 8'h03;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, rd_valid;
    logic        rd_ready = 1'b1;
    logic [7:0]  rd_data;

    spi_flash_reader_if spi ();

    spi_flash_reader #(.MAX_LEN(65535)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .addr     (addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .spi      (spi)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    logic [18:0] wr_log[$];
    logic [18:0] exp_wr[$];
    logic [7:0]  stream[$];
    logic [7:0]  flash_bytes[16];
    int unsigned rd_cnt = 0;
    int unsigned done_cnt = 0;
    logic        sel_ever = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register-port model: log writes, serve reads from flash_bytes, police access shape.
    logic        sel_d = 1'b0;
    int unsigned acc_len = 0;
    logic [2:0]  acc_addr;
    logic [15:0] acc_wdata;
    logic        acc_ok = 1'b1;

    always @(negedge clk) begin
        if (!reset_n) begin
            sel_d   = 1'b0;
            acc_len = 0;
        end else begin
            if (done) done_cnt++;
            if (rd_valid && rd_ready) stream.push_back(rd_data);
            if (spi.spi_select) begin
                sel_ever = 1'b1;
                if (!sel_d) begin
                    acc_len   = 1;
                    acc_addr  = spi.spi_addr;
                    acc_wdata = spi.spi_wdata;
                    acc_ok    = 1'b1;
                    if (!spi.spi_write_n) wr_log.push_back({spi.spi_addr, spi.spi_wdata});
                    if (!spi.spi_read_n) begin
                        spi.spi_rdata = {8'h00, (rd_cnt < 16) ? flash_bytes[rd_cnt] : 8'hFF};
                        rd_cnt++;
                    end
                end else begin
                    acc_len++;
                    if (spi.spi_addr !== acc_addr || spi.spi_wdata !== acc_wdata) acc_ok = 1'b0;
                end
                if (spi.spi_read_n === spi.spi_write_n) acc_ok = 1'b0;
            end else if (sel_d) begin
                check("access_len", acc_len, 2);
                check("access_stable", {31'd0, acc_ok}, 1);
                check("gap_strobes", {30'd0, spi.spi_read_n, spi.spi_write_n}, 3);
            end
            sel_d = spi.spi_select;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        stream.delete();
        rd_cnt   = 0;
        done_cnt = 0;
        sel_ever = 1'b0;
    endtask

    task automatic load_flash(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        for (int i = 0; i < 16; i++) flash_bytes[i] = 8'hE0 + 8'(i);
        flash_bytes[TB_HDR]     = d0;
        flash_bytes[TB_HDR + 1] = d1;
        flash_bytes[TB_HDR + 2] = d2;
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [15:0] l);
        tick();
        addr  = a;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int unsigned k = 0;
        while (!done && k < 4000) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 1);
        tick();
    endtask

    task automatic expect_frame(input string tag, input logic [23:0] a, input int unsigned l);
        exp_wr.delete();
        exp_wr.push_back({3'd3, 16'h0400});
        exp_wr.push_back({3'd1, 8'h00, TB_OPC});
        exp_wr.push_back({3'd1, 8'h00, a[23:16]});
        exp_wr.push_back({3'd1, 8'h00, a[15:8]});
        exp_wr.push_back({3'd1, 8'h00, a[7:0]});
        for (int unsigned i = 4; i < TB_HDR; i++) exp_wr.push_back({3'd1, 16'h0000});
        for (int unsigned i = 0; i < l; i++) exp_wr.push_back({3'd1, 16'h0000});
        exp_wr.push_back({3'd3, 16'h0000});
        check({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), {13'd0, wr_log[i]}, {13'd0, exp_wr[i]});
    endtask

    task automatic expect_stream(input string tag, input int unsigned n,
                                 input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0] exp_s[3];
        exp_s[0] = d0;
        exp_s[1] = d1;
        exp_s[2] = d2;
        check({tag, "_stream_count"}, stream.size(), n);
        for (int unsigned i = 0; i < n && i < stream.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {24'd0, stream[i]}, {24'd0, exp_s[i]});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   {31'd0, busy}, 0);
        check({tag, "_done"},   {31'd0, done}, 0);
        check({tag, "_valid"},  {31'd0, rd_valid}, 0);
        check({tag, "_rdata"},  {24'd0, rd_data}, 0);
        check({tag, "_sel"},    {31'd0, spi.spi_select}, 0);
        check({tag, "_rd_n"},   {31'd0, spi.spi_read_n}, 1);
        check({tag, "_wr_n"},   {31'd0, spi.spi_write_n}, 1);
        check({tag, "_addr"},   {29'd0, spi.spi_addr}, 0);
        check({tag, "_wdata"},  {16'd0, spi.spi_wdata}, 0);
    endtask

    logic [7:0]  snap_data;
    int unsigned snap_wr;
    logic        stall_ok;
    int unsigned k;

    initial begin
        spi.spi_rdata         = '0;
        spi.spi_readyfordata  = 1'b1;
        spi.spi_dataavailable = 1'b1;
        load_flash(8'h00, 8'h00, 8'h00);

        // Reset values
        repeat (3) tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();
        check("post_reset_busy", {31'd0, busy}, 0);

        // Basic two-byte frame
        clear_logs();
        load_flash(8'hAA, 8'h55, 8'h00);
        pulse_start(24'h012345, 16'd2);
        check("frame_busy", {31'd0, busy}, 1);
        wait_done("frame");
        expect_frame("frame", 24'h012345, 2);
        expect_stream("frame", 2, 8'hAA, 8'h55, 8'h00);
        check("frame_done_pulses", done_cnt, 1);
        check("frame_idle_busy", {31'd0, busy}, 0);

        // Downstream stall on the first data byte
        clear_logs();
        load_flash(8'h11, 8'h22, 8'h33);
        rd_ready = 1'b0;
        pulse_start(24'hABCDEF, 16'd3);
        k = 0;
        while (!rd_valid && k < 2000) begin
            tick();
            k++;
        end
        check("stall_valid_seen", {31'd0, rd_valid}, 1);
        check("stall_first_byte", {24'd0, rd_data}, 32'h11);
        snap_data = rd_data;
        snap_wr   = wr_log.size();
        stall_ok  = 1'b1;
        repeat (100) begin
            tick();
            if (rd_data !== snap_data || rd_valid !== 1'b1) stall_ok = 1'b0;
        end
        check("stall_data_stable", {31'd0, stall_ok}, 1);
        check("stall_no_tx", wr_log.size(), snap_wr);
        rd_ready = 1'b1;
        wait_done("stall");
        expect_frame("stall", 24'hABCDEF, 3);
        expect_stream("stall", 3, 8'h11, 8'h22, 8'h33);

        // Zero-length request
        clear_logs();
        pulse_start(24'h123456, 16'd0);
        check("len0_done", {31'd0, done}, 1);
        tick();
        check("len0_done_drop", {31'd0, done}, 0);
        check("len0_busy_drop", {31'd0, busy}, 0);
        repeat (5) tick();
        check("len0_no_select", {31'd0, sel_ever}, 0);
        check("len0_done_pulses", done_cnt, 1);

        // Start during busy is ignored; TRDY low holds off the first TX write
        clear_logs();
        load_flash(8'h5A, 8'h00, 8'h00);
        spi.spi_readyfordata = 1'b0;
        pulse_start(24'h00BEEF, 16'd1);
        repeat (10) tick();
        pulse_start(24'hFFFFFF, 16'd7);
        repeat (10) tick();
        check("trdy_hold_writes", wr_log.size(), 1);
        check("trdy_hold_busy", {31'd0, busy}, 1);
        spi.spi_readyfordata = 1'b1;
        wait_done("ignore");
        expect_frame("ignore", 24'h00BEEF, 1);
        expect_stream("ignore", 1, 8'h5A, 8'h00, 8'h00);
        check("ignore_done_pulses", done_cnt, 1);
        snap_wr = wr_log.size();
        repeat (20) tick();
        check("ignore_no_second_frame", wr_log.size(), snap_wr);
        check("ignore_idle_busy", {31'd0, busy}, 0);

        // Asynchronous reset in the middle of the header
        clear_logs();
        load_flash(8'h99, 8'h98, 8'h00);
        pulse_start(24'h102030, 16'd2);
        k = 0;
        while (wr_log.size() < 3 && k < 2000) begin
            tick();
            k++;
        end
        check("midreset_reached_header", {31'd0, (wr_log.size() >= 3)}, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        snap_wr = wr_log.size();
        repeat (4) tick();
        check("midreset_no_access", wr_log.size(), snap_wr);
        reset_n = 1'b1;
        tick();
        clear_logs();
        load_flash(8'h77, 8'h00, 8'h00);
        pulse_start(24'h0A0B0C, 16'd1);
        wait_done("after_reset");
        expect_frame("after_reset", 24'h0A0B0C, 1);
        expect_stream("after_reset", 1, 8'h77, 8'h00, 8'h00);
        check("after_reset_done_pulses", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
